// File: rtl/delay_timer_pkg.sv
// Shared definitions for the multi-channel delay timer.
//   StIdle / StRun : channel state encodings
//   chan_state_e   : enum used by every timer_channel instance
package delay_timer_pkg;
   localparam logic StIdle = 1'b0;
   localparam logic StRun  = 1'b1;

   typedef enum logic {
      IDLE = StIdle,
      RUN  = StRun
   } chan_state_e;
endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel driven by the shared prescaler tick.
//   clk, rst   : clock, synchronous active-high reset
//   tick       : shared prescaler strobe, one clock wide
//   start      : load load_value and run (restarts a running channel)
//   stop       : abort to IDLE, count held; wins over start
//   periodic   : 1 = reload on expiry, 0 = one-shot (sampled at expiry only)
//   load_value : reload value (sampled at load/reload only)
//   timeout    : registered one-clock expiry pulse
//   busy       : 1 while in RUN
//   count      : current down-counter value
module timer_channel
   import delay_timer_pkg::*;
#(
   parameter int NumberOfBits = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    periodic,
   input  logic [NumberOfBits-1:0] load_value,
   output logic                    timeout,
   output logic                    busy,
   output logic [NumberOfBits-1:0] count
);

   chan_state_e             state_q, state_d;
   logic [NumberOfBits-1:0] count_q, count_d;
   logic                    timeout_q, timeout_d;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      timeout_d = 1'b0;
      if (stop) begin
         state_d = IDLE;
      end else if (start) begin
         // Also covers start on the expiry cycle: the pulse is dropped.
         state_d = RUN;
         count_d = load_value;
      end else if (state_q == RUN && tick) begin
         if (count_q != '0) begin
            count_d = count_q - NumberOfBits'(1);
         end else begin
            timeout_d = 1'b1;
            if (periodic) count_d = load_value;
            else          state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
   assign busy    = (state_q == RUN);
   assign count   = count_q;

endmodule

// File: rtl/delay_timer_multi.sv
// Multi-channel delay timer: one free-running shared prescaler feeding
// Channels independent down-counters.
//   Clock, Reset : clock, synchronous active-high reset
//   Start, Stop  : per-channel load-and-run / abort requests
//   Periodic     : per-channel auto-reload enable
//   LoadValue    : channel i at [i*NumberOfBits +: NumberOfBits]
//   Prescale     : tick every Prescale+1 clocks
//   Timeout      : per-channel one-clock expiry pulse
//   Busy         : per-channel RUN flag
//   Count        : per-channel counter, packed like LoadValue
module delay_timer_multi
   import delay_timer_pkg::*;
#(
   parameter int NumberOfBits = 20,
   parameter int Channels     = 4,
   parameter int PrescaleBits = 8
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic [Channels-1:0]              Start,
   input  logic [Channels-1:0]              Stop,
   input  logic [Channels-1:0]              Periodic,
   input  logic [Channels*NumberOfBits-1:0] LoadValue,
   input  logic [PrescaleBits-1:0]          Prescale,
   output logic [Channels-1:0]              Timeout,
   output logic [Channels-1:0]              Busy,
   output logic [Channels*NumberOfBits-1:0] Count
);

   logic [PrescaleBits-1:0] prescaler_q, prescaler_d;
   logic                    tick;

   // >= rather than == so lowering Prescale below the current phase
   // wraps at once instead of running the full 2^PrescaleBits cycle.
   always_comb begin
      tick        = (prescaler_q >= Prescale);
      prescaler_d = tick ? '0 : prescaler_q + PrescaleBits'(1);
   end

   always_ff @(posedge Clock) begin
      if (Reset) prescaler_q <= '0;
      else       prescaler_q <= prescaler_d;
   end

   for (genvar i = 0; i < Channels; i++) begin : g_ch
      timer_channel #(
         .NumberOfBits(NumberOfBits)
      ) u_ch (
         .clk       (Clock),
         .rst       (Reset),
         .tick      (tick),
         .start     (Start[i]),
         .stop      (Stop[i]),
         .periodic  (Periodic[i]),
         .load_value(LoadValue[i*NumberOfBits +: NumberOfBits]),
         .timeout   (Timeout[i]),
         .busy      (Busy[i]),
         .count     (Count[i*NumberOfBits +: NumberOfBits])
      );
   end

endmodule

// File: tb/tb_delay_timer_multi.sv
// Directed self-checking bench for delay_timer_multi (default parameters).
module tb_delay_timer_multi;
   localparam int NB = 20;
   localparam int CH = 4;
   localparam int PB = 8;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [CH-1:0]    Start, Stop, Periodic;
   logic [CH*NB-1:0] LoadValue;
   logic [PB-1:0]    Prescale;
   logic [CH-1:0]    Timeout, Busy;
   logic [CH*NB-1:0] Count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   delay_timer_multi #(.NumberOfBits(NB), .Channels(CH), .PrescaleBits(PB)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Stop     (Stop),
      .Periodic (Periodic),
      .LoadValue(LoadValue),
      .Prescale (Prescale),
      .Timeout  (Timeout),
      .Busy     (Busy),
      .Count    (Count)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NB-1:0] cnt(input int ch);
      return Count[ch*NB +: NB];
   endfunction

   task automatic set_lv(input int ch, input logic [NB-1:0] v);
      LoadValue[ch*NB +: NB] = v;
   endtask

   // advance one edge, then sample 1 time unit after it
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = '0; Stop = '0; Periodic = '0;
      LoadValue = '0; Prescale = '0;
      step();
      step();
      total_cnt++;
      if (Timeout !== 4'b0000) $display("FAIL reset_timeout: got %b want 0000", Timeout);
      else pass_cnt++;
      total_cnt++;
      if (Busy !== 4'b0000) $display("FAIL reset_busy: got %b want 0000", Busy);
      else pass_cnt++;
      total_cnt++;
      if (Count !== '0) $display("FAIL reset_count: got %h want 0", Count);
      else pass_cnt++;
      Reset = 1'b0;
   endtask

   task automatic test_oneshot();
      Prescale = 0; Periodic[0] = 1'b0; set_lv(0, 3);
      Start[0] = 1'b1;
      step();
      Start[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (Busy[0] !== 1'b1 || cnt(0) !== NB'(3 - k) || Timeout[0] !== 1'b0)
            $display("FAIL oneshot_run%0d: busy=%b cnt=%0d to=%b want busy=1 cnt=%0d to=0",
                     k, Busy[0], cnt(0), Timeout[0], 3 - k);
         else pass_cnt++;
         if (k < 3) step();
      end
      step();
      total_cnt++;
      if (Timeout[0] !== 1'b1 || Busy[0] !== 1'b0)
         $display("FAIL oneshot_expire: to=%b busy=%b want to=1 busy=0", Timeout[0], Busy[0]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (Timeout[0] !== 1'b0) $display("FAIL oneshot_pulse_width: to=%b want 0", Timeout[0]);
      else pass_cnt++;
   endtask

   task automatic test_periodic();
      Prescale = 0; Periodic[1] = 1'b1; set_lv(1, 2);
      Start[1] = 1'b1;
      step();
      Start[1] = 1'b0;
      for (int t = 1; t <= 9; t++) begin
         step();
         total_cnt++;
         if (Timeout[1] !== ((t % 3) == 0) || Busy[1] !== 1'b1)
            $display("FAIL periodic_t%0d: to=%b busy=%b want to=%b busy=1",
                     t, Timeout[1], Busy[1], (t % 3) == 0);
         else pass_cnt++;
      end
      Stop[1] = 1'b1;
      step();
      Stop[1] = 1'b0;
      total_cnt++;
      if (Busy[1] !== 1'b0 || Timeout[1] !== 1'b0 || cnt(1) !== NB'(2))
         $display("FAIL periodic_stop: busy=%b to=%b cnt=%0d want busy=0 to=0 cnt=2",
                  Busy[1], Timeout[1], cnt(1));
      else pass_cnt++;
      begin
         int pulses = 0;
         for (int t = 0; t < 6; t++) begin
            step();
            if (Timeout[1] !== 1'b0) pulses++;
         end
         total_cnt++;
         if (pulses !== 0) $display("FAIL periodic_after_stop: pulses=%0d want 0", pulses);
         else pass_cnt++;
      end
      Periodic[1] = 1'b0;
   endtask

   task automatic test_prescale();
      // reset pins the prescaler phase: ticks land at edges 5,10 after the reset edge
      Reset = 1'b1; Prescale = 4; Periodic[3] = 1'b0; set_lv(3, 1);
      step();
      Reset = 1'b0; Start[3] = 1'b1;
      step();
      Start[3] = 1'b0;
      begin
         int n = 0;
         while (Timeout[3] !== 1'b1 && n < 20) begin
            step();
            n++;
            if (n == 3) begin
               total_cnt++;
               if (cnt(3) !== NB'(1)) $display("FAIL prescale_hold: cnt=%0d want 1", cnt(3));
               else pass_cnt++;
            end
            if (n == 4) begin
               total_cnt++;
               if (cnt(3) !== NB'(0)) $display("FAIL prescale_first_tick: cnt=%0d want 0", cnt(3));
               else pass_cnt++;
            end
         end
         total_cnt++;
         if (n !== 9) $display("FAIL prescale_latency: clocks=%0d want 9", n);
         else pass_cnt++;
      end
      total_cnt++;
      if (Busy[3] !== 1'b0) $display("FAIL prescale_idle: busy=%b want 0", Busy[3]);
      else pass_cnt++;
      Prescale = 0;
   endtask

   task automatic test_start_stop();
      set_lv(0, 7);
      Start[0] = 1'b1; Stop[0] = 1'b1;
      step();
      Start[0] = 1'b0; Stop[0] = 1'b0;
      total_cnt++;
      if (Busy[0] !== 1'b0 || cnt(0) !== NB'(0))
         $display("FAIL start_stop: busy=%b cnt=%0d want busy=0 cnt=0", Busy[0], cnt(0));
      else pass_cnt++;
   endtask

   task automatic test_restart_on_expiry();
      Prescale = 0; Periodic[2] = 1'b0; set_lv(2, 1);
      Start[2] = 1'b1;
      step();
      Start[2] = 1'b0;
      step();
      total_cnt++;
      if (cnt(2) !== NB'(0)) $display("FAIL restart_pre: cnt=%0d want 0", cnt(2));
      else pass_cnt++;
      set_lv(2, 5); Start[2] = 1'b1;
      step();
      Start[2] = 1'b0;
      total_cnt++;
      if (Timeout[2] !== 1'b0 || cnt(2) !== NB'(5) || Busy[2] !== 1'b1)
         $display("FAIL restart_expiry: to=%b cnt=%0d busy=%b want to=0 cnt=5 busy=1",
                  Timeout[2], cnt(2), Busy[2]);
      else pass_cnt++;
      Stop[2] = 1'b1;
      step();
      Stop[2] = 1'b0;
   endtask

   task automatic test_reset_midcount();
      Prescale = 0; Periodic = '0;
      set_lv(0, 10); set_lv(1, 20); set_lv(2, 30); set_lv(3, 40);
      Start = 4'b1111;
      step();
      Start = '0;
      step(); step(); step();
      for (int c = 0; c < CH; c++) begin
         total_cnt++;
         if (cnt(c) !== NB'(10 * (c + 1) - 3))
            $display("FAIL indep_ch%0d: cnt=%0d want %0d", c, cnt(c), 10 * (c + 1) - 3);
         else pass_cnt++;
      end
      Reset = 1'b1; Start = 4'b0101; Stop = 4'b0010;
      step();
      Reset = 1'b0; Start = '0; Stop = '0;
      total_cnt++;
      if (Busy !== 4'b0000 || Timeout !== 4'b0000 || Count !== '0)
         $display("FAIL reset_mid: busy=%b to=%b count=%h want all 0", Busy, Timeout, Count);
      else pass_cnt++;
      begin
         int pulses = 0;
         for (int t = 0; t < 50; t++) begin
            step();
            if (Timeout !== 4'b0000) pulses++;
         end
         total_cnt++;
         if (pulses !== 0) $display("FAIL reset_no_timeout: pulses=%0d want 0", pulses);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_prescale();
      test_start_stop();
      test_restart_on_expiry();
      test_reset_midcount();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/delay_timer_multi.md
DELAY_TIMER_MULTI -- requirements
Module: delay_timer_multi

Interface
REQ-001 SHALL have parameter NumberOfBits, default 20, meaning the width of each channel's down-counter and load value.
REQ-002 SHALL have parameter Channels, default 4, meaning the number of independent timer channels.
REQ-003 SHALL have parameter PrescaleBits, default 8, meaning the width of the shared prescaler.
REQ-004 SHALL have port Clock, input, 1 bit, the single clock; all logic SHALL be clocked on posedge Clock.
REQ-005 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port Start, input, Channels bits, per-channel load-and-run request, sampled each clock.
REQ-007 SHALL have port Stop, input, Channels bits, per-channel abort request.
REQ-008 SHALL have port Periodic, input, Channels bits: 1 = auto-reload mode, 0 = one-shot mode.
REQ-009 SHALL have port LoadValue, input, Channels*NumberOfBits bits; channel i uses bits [i*NumberOfBits +: NumberOfBits].
REQ-010 SHALL have port Prescale, input, PrescaleBits bits, tick divider: one tick every Prescale+1 clocks.
REQ-011 SHALL have port Timeout, output reg, Channels bits, one-clock expiry pulse per channel.
REQ-012 SHALL have port Busy, output, Channels bits, 1 while the channel is in RUN.
REQ-013 SHALL have port Count, output, Channels*NumberOfBits bits, current down-counter value per channel.

Function
REQ-014 Prescaler SHALL be free-running and shared: it increments every clock and, when prescaler >= Prescale, asserts Tick for that clock and wraps to 0; Prescale=0 SHALL give Tick every clock.
REQ-015 Start SHALL NOT re-phase the prescaler; first-tick latency after Start SHALL therefore be 1..Prescale+1 clocks.
REQ-016 Each channel SHALL be a two-state FSM: IDLE, RUN.
REQ-017 Start[i]=1 in either state SHALL load Count=LoadValue and enter RUN (restart if already running); no Timeout SHALL be generated in that cycle.
REQ-018 In RUN on Tick with Count>0, Count SHALL decrement by 1.
REQ-019 In RUN on Tick with Count==0, Timeout[i] SHALL be 1 for the next clock cycle only; if Periodic[i]=1, Count SHALL reload LoadValue and the channel SHALL stay in RUN; otherwise the channel SHALL enter IDLE.
REQ-020 Expiry SHALL therefore occur on the (LoadValue+1)th Tick after Start; LoadValue=0 SHALL expire on the first Tick.
REQ-021 Without Tick, Count and state SHALL hold.
REQ-022 Stop[i]=1 SHALL force IDLE, hold Count, and suppress Timeout; Stop SHALL take priority over Start in the same cycle.
REQ-023 Start coincident with expiry SHALL restart the channel and suppress that Timeout pulse.
REQ-024 Periodic and LoadValue SHALL be sampled at load/reload time only.
REQ-025 A Prescale change mid-count SHALL take effect immediately under the >= compare rule, with no lockup.
REQ-026 In IDLE, Count SHALL hold its last value and Timeout SHALL be 0.
REQ-027 Channels SHALL be fully independent apart from the shared Tick.

Reset
REQ-028 Reset=1 at a clock edge SHALL set prescaler=0, every channel to IDLE, Count=0, Timeout=0, Busy=0.
REQ-029 Reset SHALL override Start and Stop; Reset asserted mid-count SHALL abort with no Timeout.
REQ-030 The first Tick after Reset deasserts SHALL occur Prescale+1 clocks later.

Structure
REQ-031 State encodings (IDLE=0, RUN=1) SHALL be localparams in a shared include/package, delay_timer_pkg.
REQ-032 Per-channel logic SHALL be a sub-module, timer_channel, replicated by a generate loop; the prescaler SHALL live in the top level.

Verification
REQ-033 Prescale=0, LoadValue=3, one-shot, Start pulse at edge 0 -> Busy=1 and Count 3,2,1,0 after edges 0..3; Timeout=1 only after edge 4; Busy=0 after edge 4.
REQ-034 Prescale=0, LoadValue=2, Periodic=1 -> Timeout pulses every 3 clocks until Stop is asserted; after Stop, Busy=0 and no further pulses.
REQ-035 Prescale=4, LoadValue=1 -> Timeout on the 2nd Tick; Start-to-Timeout is 6..10 clocks depending on prescaler phase.
REQ-036 Start and Stop on channel 0 in the same cycle -> IDLE with no load; Start on the expiry cycle -> Timeout suppressed and Count=LoadValue.
REQ-037 Reset asserted while channels 0..3 run with different LoadValues -> all outputs 0 next clock, no Timeout; channels independent before reset.
